// File: rtl/shared_bus_arbiter.sv
// shared_bus_arbiter: round-robin sharing of one pipelined operator with in-order response FIFO
module shared_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 2,
  parameter int LAT     = 2,
  parameter int FIFO_D  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_in0,
  input  logic [NUM_REQ*DATA_W-1:0]  req_in1,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       res_valid,
  output logic [DATA_W-1:0]          res_in0,
  output logic [DATA_W-1:0]          res_in1,
  input  logic [DATA_W-1:0]          res_out,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  input  logic                       rsp_ready
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int AW   = FIFO_D > 1 ? $clog2(FIFO_D) : 1;
  localparam int CW   = $clog2(FIFO_D + 1);
  logic [ID_W-1:0]   ptr, sel, res_id, cand;
  logic [LAT-1:0]    pv;
  logic [ID_W-1:0]   pid [LAT];
  logic [DATA_W-1:0] mem_d [FIFO_D];
  logic [ID_W-1:0]   mem_id [FIFO_D];
  logic [AW-1:0]     wp, rp;
  logic [CW-1:0]     cnt;
  logic              push, pop, found;
  int                occ;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(FIFO_D - 1) ? '0 : p + 1'b1;
  endfunction
  assign push      = pv[LAT-1];
  assign rsp_valid = cnt != '0;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_id    = mem_id[rp];
  assign rsp_data  = mem_d[rp];
  // credit check and round-robin scan starting just after the last winner
  always_comb begin
    occ = int'(cnt) + int'(res_valid) + $countones(pv);
    req_ready = '0;
    sel = '0;
    cand = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!reset && occ < FIFO_D && !found && req_valid[cand]) begin
        req_ready[cand] = 1'b1;
        sel = cand;
        found = 1'b1;
      end
    end
  end
  // issue stage and in-flight id pipe aligned with the operator latency
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= ID_W'(NUM_REQ - 1);
      res_valid <= 1'b0;
      res_in0   <= '0;
      res_in1   <= '0;
      res_id    <= '0;
      pv        <= '0;
    end else begin
      res_valid <= found;
      if (found) begin
        ptr     <= sel;
        res_id  <= sel;
        res_in0 <= req_in0[sel*DATA_W +: DATA_W];
        res_in1 <= req_in1[sel*DATA_W +: DATA_W];
      end
      pv[0]  <= res_valid;
      pid[0] <= res_id;
      for (int k = 1; k < LAT; k++) begin
        pv[k]  <= pv[k-1];
        pid[k] <= pid[k-1];
      end
    end
  end
  // first-word-fall-through response FIFO; credit guarantees no push when full
  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem_d[wp]  <= res_out;
        mem_id[wp] <= pid[LAT-1];
        wp         <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_shared_bus_arbiter.sv
// tb_shared_bus_arbiter: table vectors plus scoreboard-checked corner sequences
module tb_shared_bus_arbiter;
  localparam int N = 4, DW = 2, L = 2, FD = 5;
  typedef struct { logic [N-1:0] rv; logic [N-1:0] rdy; } vec_t;
  logic clk = 1'b0, reset = 1'b1, rsp_ready = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, last_xfer = '0;
  logic [N*DW-1:0] req_in0 = '0, req_in1 = '0;
  logic res_valid, rsp_valid;
  logic [DW-1:0] res_in0, res_in1, res_out, rsp_data;
  logic [1:0] rsp_id;
  logic [DW-1:0] opq [L];
  logic [3:0] sb [$];
  logic [3:0] e;
  vec_t tbl [15];
  int n_chk = 0, n_pass = 0, g;
  shared_bus_arbiter #(.NUM_REQ(N), .DATA_W(DW), .LAT(L), .FIFO_D(FD)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_in0(req_in0), .req_in1(req_in1),
    .req_ready(req_ready), .res_valid(res_valid), .res_in0(res_in0), .res_in1(res_in1),
    .res_out(res_out), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready));
  always #5 clk = ~clk;
  // operator model: sum of operands after L cycles
  always @(posedge clk) begin
    opq[0] <= res_in0 + res_in1;
    for (int k = 1; k < L; k++) opq[k] <= opq[k-1];
  end
  assign res_out = opq[L-1];
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  // scoreboard: push on transfer, pop and compare on response handshake
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      last_xfer = '0;
    end else begin
      last_xfer = req_valid & req_ready;
      chk("onehot", int'($onehot0(req_ready)), 1);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) chk("pop_empty", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_id", rsp_id, e[3:2]);
          chk("rsp_data", rsp_data, e[1:0]);
        end
      end
      for (int i = 0; i < N; i++)
        if (last_xfer[i]) sb.push_back({2'(i), DW'(req_in0[i*DW +: DW] + req_in1[i*DW +: DW])});
      chk("credit", int'(sb.size() <= FD), 1);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [N-1:0] rv);
    for (int i = 0; i < N; i++)
      if (last_xfer[i] || !req_valid[i]) begin
        req_in0[i*DW +: DW] = DW'($urandom);
        req_in1[i*DW +: DW] = DW'($urandom);
      end
    req_valid = rv;
  endtask
  task automatic rst_seq();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{4'b0000, 4'b0000}; tbl[1]  = '{4'b0001, 4'b0001}; tbl[2]  = '{4'b1111, 4'b0010};
    tbl[3]  = '{4'b1111, 4'b0100}; tbl[4]  = '{4'b1111, 4'b1000}; tbl[5]  = '{4'b1111, 4'b0001};
    tbl[6]  = '{4'b0010, 4'b0010}; tbl[7]  = '{4'b0101, 4'b0100}; tbl[8]  = '{4'b0101, 4'b0001};
    tbl[9]  = '{4'b0101, 4'b0100}; tbl[10] = '{4'b1000, 4'b1000}; tbl[11] = '{4'b0000, 4'b0000};
    tbl[12] = '{4'b0110, 4'b0010}; tbl[13] = '{4'b0110, 4'b0100}; tbl[14] = '{4'b0000, 4'b0000};
    req_valid = 4'b1111;
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_res_in0", res_in0, 0);
    chk("rst_res_in1", res_in1, 0);
    tick();
    reset = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    drive(4'b0001);
    req_in0[1:0] = 2'b10;
    req_in1[1:0] = 2'b01;
    @(negedge clk); chk("a_ready", req_ready, 1); tick();
    drive(4'b0000);
    @(negedge clk); chk("a_res_valid", res_valid, 1); chk("a_res_in0", res_in0, 2); chk("a_res_in1", res_in1, 1);
    chk("a_rsp_t1", rsp_valid, 0); tick();
    @(negedge clk); chk("a_res_idle", res_valid, 0); chk("a_rsp_t2", rsp_valid, 0); tick();
    @(negedge clk); chk("a_rsp_t3", rsp_valid, 0); tick();
    @(negedge clk); chk("a_rsp_t4", rsp_valid, 1); chk("a_rsp_id", rsp_id, 0); chk("a_rsp_data", rsp_data, 3);
    chk("a_hold_in0", res_in0, 2); tick();
    rst_seq();
    rsp_ready = 1'b1;
    for (int v = 0; v < 15; v++) begin
      drive(tbl[v].rv);
      @(negedge clk);
      chk($sformatf("tbl%0d", v), req_ready, tbl[v].rdy);
      tick();
    end
    drive('0);
    repeat (8) tick();
    rsp_ready = 1'b0;
    g = 0;
    for (int c = 0; c < 12; c++) begin
      drive(4'b0001);
      @(negedge clk);
      if (req_ready[0]) g++;
      tick();
    end
    chk("c_grants", g, FD);
    rsp_ready = 1'b1;
    @(negedge clk); chk("c_pop_cycle", req_ready, 0); tick();
    rsp_ready = 1'b0;
    @(negedge clk); chk("c_regrant", req_ready, 1); tick();
    @(negedge clk); chk("c_refull", req_ready, 0); tick();
    drive('0);
    rsp_ready = 1'b1;
    repeat (10) tick();
    rsp_ready = 1'b0;
    repeat (3) begin drive(4'b0001); tick(); end
    drive('0); tick();
    @(negedge clk); chk("d_pre", rsp_valid, 1); tick();
    rsp_ready = 1'b1;
    @(negedge clk); chk("d_pushpop", rsp_valid, 1); tick();
    @(negedge clk); chk("d_cnt2", rsp_valid, 1); tick();
    @(negedge clk); chk("d_cnt1", rsp_valid, 1); tick();
    @(negedge clk); chk("d_empty", rsp_valid, 0); tick();
    rsp_ready = 1'b0;
    repeat (3) begin drive(4'b0001); tick(); end
    drive('0); tick();
    reset = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk); chk("e_rst_ready", req_ready, 0); tick();
    reset = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); chk($sformatf("e_no_rsp%0d", c), rsp_valid, 0); tick();
    end
    drive(4'b1111);
    @(negedge clk); chk("e_ptr", req_ready, 1); tick();
    drive('0);
    repeat (8) tick();
    chk("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
